// File: rtl/lut_ff_mux_array.sv
// ---------------------------------------------------------------------------
// lut_ff_mux_array
//   Multi-channel LUT / flip-flop / output-mux cell. Each channel owns a
//   K-input LUT whose truth table can be rewritten at run time, a DEPTH-stage
//   register pipeline fed by the LUT and a toggle flip-flop that flips
//   whenever the LUT output is 1. One block-wide mode select chooses which
//   node drives each channel output.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ce         clock enable for pipeline and toggle registers
//   mux_sel    output mode: 0 LUT, 1 stage-1, 2 stage-DEPTH, 3 toggle FF
//   in         channel c inputs at in[c*K +: K]
//   cfg_valid  truth-table write request
//   cfg_ready  write accept indication (low for one cycle after a write)
//   cfg_ch     target channel of the write (values >= CH are ignored)
//   cfg_data   new truth table, bit i = LUT output for input value i
//   q          per-channel selected output
// ---------------------------------------------------------------------------
module lut_ff_mux_array #(
  parameter int K = 4,
  parameter int CH = 2,
  parameter int DEPTH = 2,
  parameter logic [(2**K)-1:0] INIT = 16'h0010,
  localparam int N = 2**K,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [1:0]    mux_sel,
  input  logic [CH*K-1:0] in,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [N-1:0]  cfg_data,
  output logic [CH-1:0] q
);

  logic [N-1:0]  table_q [CH];
  logic [N-1:0]  table_d [CH];
  logic [CH-1:0] stage_q [DEPTH];
  logic [CH-1:0] stage_d [DEPTH];
  logic [CH-1:0] tog_q;
  logic [CH-1:0] tog_d;
  logic          ready_q;
  logic          ready_d;
  logic [CH-1:0] lut_s;
  logic          accept_s;

  assign cfg_ready = ready_q;
  assign accept_s  = cfg_valid & ready_q;

  // LUT evaluation: always reads the currently registered table, so a write
  // accepted on an edge is only visible from the following cycle.
  always_comb begin
    lut_s = '0;
    for (int c = 0; c < CH; c++) begin
      lut_s[c] = table_q[c][in[c*K +: K]];
    end
  end

  // Next-state for tables and the config handshake. Channel numbers that do
  // not match any channel complete the handshake without touching a table.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      if (accept_s && (CW'(c) == cfg_ch)) begin
        table_d[c] = cfg_data;
      end else begin
        table_d[c] = table_q[c];
      end
    end
    if (accept_s) begin
      ready_d = 1'b0;
    end else begin
      ready_d = 1'b1;
    end
  end

  // Next-state for the pipeline and toggle registers, all gated by ce.
  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      stage_d[n] = stage_q[n];
    end
    tog_d = tog_q;
    if (ce) begin
      stage_d[0] = lut_s;
      for (int n = 1; n < DEPTH; n++) begin
        stage_d[n] = stage_q[n-1];
      end
      tog_d = tog_q ^ lut_s;
    end else begin
      tog_d = tog_q;
    end
  end

  // State registers; reset reloads INIT and reopens the config port at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        table_q[c] <= INIT;
      end
      for (int n = 0; n < DEPTH; n++) begin
        stage_q[n] <= '0;
      end
      tog_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        table_q[c] <= table_d[c];
      end
      for (int n = 0; n < DEPTH; n++) begin
        stage_q[n] <= stage_d[n];
      end
      tog_q   <= tog_d;
      ready_q <= ready_d;
    end
  end

  // Output select; combinational so a mode change is seen in the same cycle.
  always_comb begin
    case (mux_sel)
      2'd0:    q = lut_s;
      2'd1:    q = stage_q[0];
      2'd2:    q = stage_q[DEPTH-1];
      2'd3:    q = tog_q;
      default: q = '0;
    endcase
  end

endmodule

// File: tb/tb_lut_ff_mux_array.sv
module tb_lut_ff_mux_array;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [1:0]  mux_sel;
  logic [7:0]  in_v;
  logic [3:0]  in_a;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_ready_a;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_data;
  logic [1:0]  q;
  logic [0:0]  q_a;

  typedef struct {
    int         id;
    logic [1:0] mask;
    logic [1:0] val;
    logic       ur;
    logic       r;
    logic       ua;
    logic       a;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  lut_ff_mux_array #(.K(4), .CH(2), .DEPTH(2), .INIT(16'h0010)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mux_sel(mux_sel), .in(in_v),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_data(cfg_data), .q(q)
  );

  // Single-channel build: cfg_ch=1 is out of range here.
  lut_ff_mux_array #(.K(4), .CH(1), .DEPTH(2), .INIT(16'h0010)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .mux_sel(mux_sel), .in(in_a),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a), .cfg_ch(cfg_ch),
    .cfg_data(cfg_data), .q(q_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int id, input logic [1:0] mask, input logic [1:0] val,
                     input logic ur, input logic r, input logic ua, input logic a);
    exp_t x;
    x.id = id; x.mask = mask; x.val = val; x.ur = ur; x.r = r; x.ua = ua; x.a = a;
    sb.push_back(x);
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ((q & e.mask) !== (e.val & e.mask)) begin
          errors++;
          $display("FAIL q id=%0d mode=%0d got=%b exp=%b mask=%b", e.id, mux_sel, q, e.val, e.mask);
        end
        if (e.ur) begin
          checks++;
          if (cfg_ready !== e.r || cfg_ready_a !== e.r) begin
            errors++;
            $display("FAIL cfg_ready id=%0d got=%b/%b exp=%b", e.id, cfg_ready, cfg_ready_a, e.r);
          end
        end
        if (e.ua) begin
          checks++;
          if (q_a !== e.a) begin
            errors++;
            $display("FAIL q_aux id=%0d got=%b exp=%b", e.id, q_a, e.a);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; ce = 1'b1; mux_sel = 2'd0; in_v = 8'h44; in_a = 4'h9;
    cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_data = 16'h0000;

    // Reset held: registered modes are 0, LUT mode reads INIT bit 4.
    for (int m = 0; m < 4; m++) begin
      step();
      mux_sel = 2'(m);
      chk(m, 2'b11, (m == 0) ? 2'b11 : 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    step(); rst = 1'b1; in_v = 8'h00; mux_sel = 2'd0;

    // Latency
    step(); in_v = 8'h04; mux_sel = 2'd0; chk(10, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); mux_sel = 2'd1;               chk(11, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); mux_sel = 2'd2; in_v = 8'h00; chk(12, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(13, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(14, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Truth-table miss, then ce=0 hold with the pipeline full of 1s on ch0
    step(); in_v = 8'h11; mux_sel = 2'd0; chk(20, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); in_v = 8'h04;                 chk(21, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); mux_sel = 2'd1;               chk(22, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); ce = 1'b0; in_v = 8'h11; mux_sel = 2'd2;
                                          chk(23, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(24, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); mux_sel = 2'd1;               chk(25, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); ce = 1'b1; in_v = 8'h00; mux_sel = 2'd3;
                                          chk(26, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Config write ch1 <= FFFF (out of range for the single-channel build)
    step(); cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_data = 16'hFFFF; in_v = 8'h90; mux_sel = 2'd0;
                                          chk(30, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); cfg_valid = 1'b0; mux_sel = 2'd1;
                                          chk(31, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    step();                               chk(32, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); mux_sel = 2'd0;               chk(33, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);

    // Toggle on ch0
    step(); in_v = 8'h04; mux_sel = 2'd3; chk(40, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(41, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(42, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(43, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); ce = 1'b0;                    chk(44, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(45, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();                               chk(46, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); ce = 1'b1; in_v = 8'h01;      chk(47, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_data = 16'hFFFF;
                                          chk(48, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // ch0 now all-ones: fill the pipeline, then async reset between edges
    step(); cfg_valid = 1'b0; mux_sel = 2'd0;
                                          chk(50, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); mux_sel = 2'd1;               chk(51, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); mux_sel = 2'd2; cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_data = 16'h0000;
                                          chk(52, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); cfg_valid = 1'b0; rst = 1'b0; mux_sel = 2'd1;
                                          chk(53, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); mux_sel = 2'd2;               chk(54, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); mux_sel = 2'd3;               chk(55, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); rst = 1'b1; mux_sel = 2'd0; in_v = 8'h01;
                                          chk(56, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); in_v = 8'h40;                 chk(57, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
